num_sweep_gen: RTL
==================

// Module: num_sweep_gen
//
// PURPOSE
//   Stimulus source for num_detector: drives the 5-bit `number` bus through a
//   FIRST..LAST sweep (up or down), holding each value DWELL clocks. It is the
//   driving end of the number->LED path and replaces bench loops on the FPGA,
//   where switches or a button pulse start, pause and abort the sweep.
//
// PARAMETERS
//   WIDTH  5   width of number bus
//   FIRST  0   lowest sweep value
//   LAST   30  highest sweep value; FIRST <= LAST < 2**WIDTH
//   DWELL  10  clocks each value is presented; >= 1
//
// PORTS
//   clk     in   1      system clock, rising edge
//   rst     in   1      async reset, active-high
//   start   in   1      begin sweep (level, sampled per clock)
//   stop    in   1      abort sweep
//   hold    in   1      freeze dwell counter and number while high
//   dir     in   1      0 = up (FIRST->LAST), 1 = down (LAST->FIRST); sampled at start
//   number  out  WIDTH  value to num_detector
//   valid   out  1      number is part of an active sweep
//   busy    out  1      sweep in progress (RUN)
//   done    out  1      sweep completed
//
// BEHAVIOUR
//   - rst=1 (async, any state): state=IDLE, number=0, valid=0, busy=0, done=0,
//     dwell counter=0, latched dir=0. All outputs registered.
//   - States: IDLE, RUN, DONE.
//   - Priority per clock: stop > start > hold > dwell advance.
//   - IDLE/DONE + start=1: next clock RUN; number=FIRST (dir=0) or LAST (dir=1);
//     valid=1, busy=1, done=0, counter=0, dir latched. start in RUN: ignored.
//   - RUN, hold=0: counter+1 each clock. At counter==DWELL-1:
//       not at end value -> number +/-1 per latched dir, counter=0;
//       at end value (LAST up / FIRST down) -> DONE: valid=0, busy=0, done=1.
//   - RUN, hold=1: counter and number frozen; valid/busy stay 1.
//   - Each value visible exactly DWELL clocks with hold low; full sweep occupies
//     (LAST-FIRST+1)*DWELL clocks in RUN. DWELL=1: new value every clock.
//   - stop=1 (any state): next clock IDLE; valid=0, busy=0, done=0, counter=0;
//     number keeps its last value (LEDs stay showing it).
//   - DONE: done=1 held, number holds end value until start or stop.
//   - Arithmetic: counter width $clog2(DWELL+1); number never leaves
//     [FIRST, LAST]; no wrap through 2**WIDTH.
//   - FIRST==LAST: one value for DWELL clocks, then DONE.
//
// CONFIGURATION
//   SWEEP_LOOP_EN defined: at end value the sweep wraps to its start value
//     (FIRST up / LAST down), stays RUN with valid=busy=1; done is a single-clock
//     pulse coinciding with the wrap cycle; DONE state unused; only stop/rst end.
//   SWEEP_LOOP_EN undefined: single sweep, behaviour as above (DONE, done held).
//
// TESTING
//   1. Defaults, start pulse dir=0 -> number 0,1..30 each 10 clocks, valid=1;
//      clock 310 after start: valid=0, busy=0, done=1, number=30.
//   2. dir=1 start -> number 30 down to 0, 10 clocks each, then done=1, number=0.
//   3. hold=1 for 5 clocks while number=3 -> number=3 for 15 clocks, rest unchanged.
//   4. stop at number=12 -> next clock valid=0, busy=0, number=12; start asserted
//      mid-RUN (number=5) -> no restart, sweep continues.
//   5. rst pulse mid-RUN at number=7 -> immediately (no clock) number=0, valid=0,
//      busy=0, done=0; next start restarts cleanly at 0.
//   6. SWEEP_LOOP_EN, DWELL=2, LAST=3 -> 0,0,1,1,2,2,3,3,0,0..; done=1 one clock
//      at each 3->0 wrap; busy stays 1.

Source files
------------

// File: rtl/num_sweep_gen.sv
// num_sweep_gen: drives a FIRST..LAST (or LAST..FIRST) number sweep, holding
// each value DWELL clocks, as the stimulus source for num_detector.
// Optional feature macro: SWEEP_LOOP_EN. When it is defined, the sweep wraps
// to its start value instead of finishing, and done pulses on each wrap.
module num_sweep_gen #(
    parameter int WIDTH = 5,
    parameter int FIRST = 0,
    parameter int LAST  = 30,
    parameter int DWELL = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             dir,
    output logic [WIDTH-1:0] number,
    output logic             valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0]    CNT_MAX = CW'(DWELL - 1);
    localparam logic [WIDTH-1:0] FIRST_V = WIDTH'(FIRST);
    localparam logic [WIDTH-1:0] LAST_V  = WIDTH'(LAST);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] num_d;
    logic             dir_q, dir_d;
    logic             valid_d, busy_d, done_d;
    logic             at_last, at_end;

    // Last dwell clock of the current value, and current value is the sweep end.
    assign at_last = (cnt_q == CNT_MAX);
    assign at_end  = (number == (dir_q ? FIRST_V : LAST_V));

    // State register plus all registered outputs and datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            number  <= '0;
            dir_q   <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            number  <= num_d;
            dir_q   <= dir_d;
            valid   <= valid_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next-state: stop beats start; start only acts outside RUN.
    always_comb begin
        state_d = state_q;
        if (stop)
            state_d = IDLE;
        else if (start && state_q != RUN)
            state_d = RUN;
        else if (state_q == RUN && !hold && at_last && at_end)
`ifdef SWEEP_LOOP_EN
            state_d = RUN;
`else
            state_d = DONE;
`endif
    end

    // Next outputs/datapath: stop > start > hold > dwell advance.
    always_comb begin
        num_d   = number;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        valid_d = valid;
        busy_d  = busy;
        done_d  = done;
        if (stop) begin
            // number is left alone so the LEDs keep showing the last value
            cnt_d   = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else if (start && state_q != RUN) begin
            num_d   = dir ? LAST_V : FIRST_V;
            dir_d   = dir;
            cnt_d   = '0;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end else if (state_q == RUN) begin
`ifdef SWEEP_LOOP_EN
            done_d = 1'b0;   // done is a one-clock wrap pulse in loop mode
`endif
            if (!hold) begin
                if (!at_last) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                    if (at_end) begin
`ifdef SWEEP_LOOP_EN
                        num_d  = dir_q ? LAST_V : FIRST_V;
                        done_d = 1'b1;
`else
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        num_d = dir_q ? number - WIDTH'(1) : number + WIDTH'(1);
                    end
                end
            end
        end
    end
endmodule
